mem_port_arbiter: RTL and testbench

- Shares one single-ported BRAM port between the CPU instruction port and the CPU data port, so the core can run from one unified memory.
- Sits between cpu_top (its en/we/addr/data inst and data ports) and the memory.
- Runs one transaction at a time through an issue/wait/respond FSM with a fixed memory read latency.
- Priority: data wins by default, with a starvation guard for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one BRAM port shared by instruction and data ports.
// Define MEM_ARB_RR_EN for round-robin instead of data priority + starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_en,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        lat_cnt, lat_cnt_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              req_any;
  logic              pick_d;
  logic              grant;

  assign req_any = i_en | d_en;
  assign grant   = (state == IDLE) & req_any;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  always_comb begin
    pick_d = 1'b0;
    unique case (1'b1)
      i_en && d_en:  pick_d = ~last_d;
      d_en && !i_en: pick_d = 1'b1;
      default:       pick_d = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      last_d <= 1'b0;
    else if (grant)
      last_d <= pick_d;
  end
`else
  logic [3:0] starve;
  logic       force_i;

  // a saturated counter hands the next grant to a waiting fetch
  assign force_i = i_en & (starve == 4'(STARVE_MAX));
  assign pick_d  = d_en & ~force_i;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      starve <= '0;
    else if (grant) begin
      if (!pick_d)
        starve <= '0;
      else if (i_en && starve != 4'(STARVE_MAX))
        starve <= starve + 4'd1;
    end
  end
`endif

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    unique case (state)
      IDLE: if (req_any) state_nx = ISSUE;
      ISSUE: begin
        if (owner && req_we != 4'b0)
          state_nx = RESP;
        else begin
          state_nx   = WAIT;
          lat_cnt_nx = 3'(RD_LAT);
        end
      end
      WAIT: begin
        lat_cnt_nx = lat_cnt - 3'd1;
        if (lat_cnt == 3'd1) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      owner     <= 1'b0;
      req_addr  <= '0;
      req_we    <= '0;
      req_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      if (grant) begin
        owner     <= pick_d;
        req_addr  <= pick_d ? d_addr : i_addr;
        req_we    <= pick_d ? d_we : 4'b0;
        req_wdata <= pick_d ? d_wdata : '0;
      end
      if (state == WAIT && lat_cnt == 3'd1) begin
        if (owner) d_rdata <= mem_rdata;
        else       i_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en ? req_we : 4'b0;
  assign mem_addr  = mem_en ? req_addr : '0;
  assign mem_wdata = mem_en ? req_wdata : '0;
  assign busy      = (state != IDLE);
  assign i_done    = (state == RESP) & ~owner;
  assign d_done    = (state == RESP) & owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter.
// Two instances: RD_LAT=1 for most cases, RD_LAT=3 for the latency sweep.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_en = 0, i_done, d_en = 0, d_done;
  logic [31:0] i_addr = 0, i_rdata, d_addr = 0, d_wdata = 0, d_rdata;
  logic [3:0]  d_we = 0, mem_we;
  logic        mem_en, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_i_en = 0, b_i_done, b_d_en = 0, b_d_done;
  logic [31:0] b_i_addr = 0, b_i_rdata, b_d_addr = 0, b_d_wdata = 0;
  logic [31:0] b_d_rdata;
  logic [3:0]  b_d_we = 0, b_mem_we;
  logic        b_mem_en, b_busy, b_owner;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut (
    .aclk(clk), .aresetn(rst_n),
    .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_lat3 (
    .aclk(clk), .aresetn(rst_n),
    .i_en(b_i_en), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
    .i_done(b_i_done),
    .d_en(b_d_en), .d_we(b_d_we), .d_addr(b_d_addr),
    .d_wdata(b_d_wdata), .d_rdata(b_d_rdata), .d_done(b_d_done),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'h04:   return 32'h13579BDF;
      8'h08:   return 32'h0BADF00D;
      8'h09:   return 32'h600DCAFE;
      8'h10:   return 32'h00A00093;
      8'h40:   return 32'h11223344;
      8'h80:   return 32'hCAFEF00D;
      default: return {24'hA5A5A5, idx};
    endcase
  endfunction

  logic [31:0]  wmem [256];
  logic [255:0] wval = '0;

  function automatic logic [31:0] rd_word(input logic [7:0] idx);
    return wval[idx] ? wmem[idx] : init_word(idx);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  logic [31:0] a_rd = 0, b_p0 = 0, b_p1 = 0, b_p2 = 0;
  assign mem_rdata   = a_rd;
  assign b_mem_rdata = b_p2;

  always @(posedge clk) begin
    if (mem_en) begin
      a_rd <= rd_word(mem_addr[9:2]);
      if (mem_we != 4'b0) begin
        wmem[mem_addr[9:2]] <= merge(rd_word(mem_addr[9:2]), mem_we,
                                     mem_wdata);
        wval[mem_addr[9:2]] <= 1'b1;
      end
    end
    b_p0 <= rd_word(b_mem_addr[9:2]);
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end

  logic [15:0] glog = '0;
  int gcnt = 0, n_i_done = 0, both = 0, b_issue = -1;
  always @(negedge clk) begin
    if (mem_en) begin
      glog <= {glog[14:0], owner};
      gcnt <= gcnt + 1;
    end
    if (i_done) n_i_done <= n_i_done + 1;
    if (i_done && d_done) both <= both + 1;
    if (b_mem_en) b_issue <= cyc;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int sel, input string tag, output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((sel == 0 && i_done) || (sel == 1 && d_done) ||
          (sel == 2 && b_i_done)) begin
        at = cyc;
        return;
      end
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

`ifdef MEM_ARB_RR_EN
  localparam logic [9:0] EXP_ORDER = 10'b1010101010;
`else
  localparam logic [9:0] EXP_ORDER = 10'b1111011110;
`endif

  int n, at, d1, g0, ni;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_done", 32'({i_done, d_done}), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    sync;

    // contention: both ports held continuously
    i_en = 1; i_addr = 32'h0; d_en = 1; d_addr = 32'h300; d_we = 0;
    g0 = gcnt;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (gcnt >= g0 + 10) break;
    end
    #1;
    i_en = 0; d_en = 0;
    chk("grant_order", 32'(glog[9:0]), 32'(EXP_ORDER));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("cont_idle", 32'(busy), 0);

    // single fetch
    sync;
    i_en = 1; i_addr = 32'h40; n = cyc;
    @(negedge clk);
    chk("fetch_idle", 32'(busy), 0);
    @(negedge clk);
    chk("fetch_mem_en", 32'(mem_en), 1);
    chk("fetch_mem_addr", mem_addr, 32'h40);
    chk("fetch_mem_we", 32'(mem_we), 0);
    chk("fetch_owner", 32'(owner), 0);
    wait_done(0, "fetch", at);
    chk("fetch_lat", at - n, 3);
    chk("fetch_rdata", i_rdata, 32'h00A00093);
    sync;
    i_en = 0;
    @(negedge clk);
    chk("fetch_pulse", 32'(i_done), 0);
    chk("fetch_hold", i_rdata, 32'h00A00093);

    // data write then readback
    sync;
    ni = n_i_done;
    d_en = 1; d_we = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    n = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("wr_mem_en", 32'(mem_en), 1);
    chk("wr_mem_we", 32'(mem_we), 32'h3);
    chk("wr_mem_addr", mem_addr, 32'h100);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_owner", 32'(owner), 1);
    wait_done(1, "wr", at);
    chk("wr_lat", at - n, 2);
    sync;
    d_we = 0; n = cyc;
    wait_done(1, "rdbk", at);
    chk("rdbk_lat", at - n, 3);
    chk("rdbk_data", d_rdata, 32'h1122BEEF);
    sync;
    d_en = 0;
    chk("wr_no_i_done", n_i_done - ni, 0);

    // request dropped after grant
    @(negedge clk);
    sync;
    d_en = 1; d_we = 0; d_addr = 32'h200; n = cyc;
    sync;
    d_en = 0; d_addr = 32'h300;
    @(negedge clk);
    chk("drop_mem_addr", mem_addr, 32'h200);
    wait_done(1, "drop", at);
    chk("drop_lat", at - n, 3);
    chk("drop_data", d_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("drop_busy", 32'(busy), 0);
    chk("drop_pulse", 32'(d_done), 0);

    // async reset during WAIT
    ni = n_i_done;
    sync;
    i_en = 1; i_addr = 32'h80; n = cyc;
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_i_rdata", i_rdata, 0);
    chk("arst_d_rdata", d_rdata, 0);
    chk("arst_owner_done", 32'({owner, i_done, d_done, mem_en}), 0);
    i_en = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_no_done", n_i_done - ni, 0);
    sync;
    i_en = 1; i_addr = 32'h10; n = cyc;
    wait_done(0, "post_rst", at);
    chk("post_rst_lat", at - n, 3);
    chk("post_rst_data", i_rdata, 32'h13579BDF);
    sync;
    i_en = 0;

    // RD_LAT=3 back-to-back fetches
    b_i_en = 1; b_i_addr = 32'h20; n = cyc;
    wait_done(2, "lat3_a", at);
    chk("lat3_first", at - n, 5);
    chk("lat3_data_a", b_i_rdata, 32'h0BADF00D);
    d1 = at;
    sync;
    b_i_addr = 32'h24;
    wait_done(2, "lat3_b", at);
    chk("lat3_issue_gap", b_issue - d1, 2);
    chk("lat3_second", at - d1, 6);
    chk("lat3_data_b", b_i_rdata, 32'h600DCAFE);
    sync;
    b_i_en = 0;

    chk("never_both_done", both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
